// File: rtl/ex_pkg.sv
// Shared ALU operation codes and multiplier FSM states for the execute stage.
package ex_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_MUL = 4'b1000;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier keeping the low DATA_W bits of an unsigned product.
module seq_multiplier
  import ex_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ITERS  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              flush,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              stall,
  output logic              done,
  output logic [DATA_W-1:0] product
);

  localparam int unsigned CNT_W = $clog2(ITERS + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ITERS - 1);

  mul_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= MUL_IDLE;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (flush) begin
      state <= MUL_IDLE;
    end else begin
      case (state)
        MUL_IDLE: begin
          if (start) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
            state  <= MUL_BUSY;
          end
        end
        MUL_BUSY: begin
          if (mcand[0]) acc <= acc + mplier;
          mcand  <= mcand >> 1;
          mplier <= mplier << 1;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == LAST) state <= MUL_DONE;
        end
        MUL_DONE: state <= MUL_IDLE;
        default:  state <= MUL_IDLE;
      endcase
    end
  end

  // Stall covers the start cycle too, so upstream freezes before BUSY is entered.
  assign stall   = !flush && ((state == MUL_IDLE && start) || state == MUL_BUSY);
  assign done    = (state == MUL_DONE);
  assign product = acc;

endmodule

// File: rtl/ex_mem_stage.sv
// Execute stage with operand forwarding, one-cycle ALU, iterative multiply and EX/MEM register.
module ex_mem_stage
  import ex_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned REG_AW    = 5,
  parameter int unsigned MUL_ITERS = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] ReadData1_in,
  input  logic [DATA_W-1:0] ReadData2_in,
  input  logic [DATA_W-1:0] SignExtend_in,
  input  logic [REG_AW-1:0] rs_in,
  input  logic [REG_AW-1:0] rt_in,
  input  logic [REG_AW-1:0] rd_in,
  input  logic              RegWrite,
  input  logic              MemtoReg,
  input  logic              MemWrite,
  input  logic              MemRead,
  input  logic              ALUSrc,
  input  logic              RegDst,
  input  logic [3:0]        ALUOp,
  input  logic              flush_i,
  input  logic              WB_RegWrite,
  input  logic [REG_AW-1:0] WB_WriteReg,
  input  logic [DATA_W-1:0] WB_Data,
  output logic              stall_o,
  output logic [DATA_W-1:0] ALUResult_out,
  output logic [DATA_W-1:0] WriteData_out,
  output logic [REG_AW-1:0] WriteReg_out,
  output logic              RegWriteOut,
  output logic              MemtoRegOut,
  output logic              MemWriteOut,
  output logic              MemReadOut
);

  logic [DATA_W-1:0] fwd_a;
  logic [DATA_W-1:0] fwd_b;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] alu_y;
  logic [4:0]        shamt;
  logic              mul_stall;
  logic              mul_done;
  logic [DATA_W-1:0] mul_product;

  // MEM result beats WB data; register 0 is never a forwarding target.
  always_comb begin
    fwd_a = ReadData1_in;
    if (RegWriteOut && WriteReg_out == rs_in && rs_in != '0)
      fwd_a = ALUResult_out;
    else if (WB_RegWrite && WB_WriteReg == rs_in && rs_in != '0)
      fwd_a = WB_Data;

    fwd_b = ReadData2_in;
    if (RegWriteOut && WriteReg_out == rt_in && rt_in != '0)
      fwd_b = ALUResult_out;
    else if (WB_RegWrite && WB_WriteReg == rt_in && rt_in != '0)
      fwd_b = WB_Data;
  end

  assign op_b  = ALUSrc ? SignExtend_in : fwd_b;
  assign shamt = SignExtend_in[10:6];

  always_comb begin
    alu_y = '0;
    case (ALUOp)
      ALU_AND: alu_y = fwd_a & op_b;
      ALU_OR:  alu_y = fwd_a | op_b;
      ALU_ADD: alu_y = fwd_a + op_b;
      ALU_SUB: alu_y = fwd_a - op_b;
      ALU_SLT: alu_y = DATA_W'($signed(fwd_a) < $signed(op_b));
      ALU_NOR: alu_y = ~(fwd_a | op_b);
      ALU_SLL: alu_y = fwd_b << shamt;
      default: alu_y = '0;
    endcase
  end

  seq_multiplier #(
    .DATA_W (DATA_W),
    .ITERS  (MUL_ITERS)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (ALUOp == ALU_MUL),
    .flush   (flush_i),
    .a       (fwd_a),
    .b       (op_b),
    .stall   (mul_stall),
    .done    (mul_done),
    .product (mul_product)
  );

  assign stall_o = rst_n && mul_stall;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ALUResult_out <= '0;
      WriteData_out <= '0;
      WriteReg_out  <= '0;
      RegWriteOut   <= 1'b0;
      MemtoRegOut   <= 1'b0;
      MemWriteOut   <= 1'b0;
      MemReadOut    <= 1'b0;
    end else if (flush_i || stall_o) begin
      RegWriteOut <= 1'b0;
      MemtoRegOut <= 1'b0;
      MemWriteOut <= 1'b0;
      MemReadOut  <= 1'b0;
    end else begin
      ALUResult_out <= mul_done ? mul_product : alu_y;
      WriteData_out <= fwd_b;
      WriteReg_out  <= RegDst ? rd_in : rt_in;
      RegWriteOut   <= RegWrite;
      MemtoRegOut   <= MemtoReg;
      MemWriteOut   <= MemWrite;
      MemReadOut    <= MemRead;
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Table-driven bench for ex_mem_stage with a scoreboard queue of expected EX/MEM contents.
module tb_ex_mem_stage;
  import ex_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ReadData1_in, ReadData2_in, SignExtend_in;
  logic [4:0]  rs_in, rt_in, rd_in;
  logic        RegWrite, MemtoReg, MemWrite, MemRead, ALUSrc, RegDst;
  logic [3:0]  ALUOp;
  logic        flush_i;
  logic        WB_RegWrite;
  logic [4:0]  WB_WriteReg;
  logic [31:0] WB_Data;
  logic        stall_o;
  logic [31:0] ALUResult_out, WriteData_out;
  logic [4:0]  WriteReg_out;
  logic        RegWriteOut, MemtoRegOut, MemWriteOut, MemReadOut;

  ex_mem_stage #(.DATA_W(32), .REG_AW(5), .MUL_ITERS(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .ReadData1_in(ReadData1_in), .ReadData2_in(ReadData2_in), .SignExtend_in(SignExtend_in),
    .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in),
    .RegWrite(RegWrite), .MemtoReg(MemtoReg), .MemWrite(MemWrite), .MemRead(MemRead),
    .ALUSrc(ALUSrc), .RegDst(RegDst), .ALUOp(ALUOp), .flush_i(flush_i),
    .WB_RegWrite(WB_RegWrite), .WB_WriteReg(WB_WriteReg), .WB_Data(WB_Data),
    .stall_o(stall_o), .ALUResult_out(ALUResult_out), .WriteData_out(WriteData_out),
    .WriteReg_out(WriteReg_out), .RegWriteOut(RegWriteOut), .MemtoRegOut(MemtoRegOut),
    .MemWriteOut(MemWriteOut), .MemReadOut(MemReadOut)
  );

  always #5 clk = ~clk;

  // ctl = {RegWrite, MemtoReg, MemWrite, MemRead, ALUSrc, RegDst}
  typedef struct {
    logic [3:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [31:0] d1, d2, imm;
    logic [5:0]  ctl;
    logic        wbwe;
    logic [4:0]  wbreg;
    logic [31:0] wbdata;
    logic [31:0] eres, ewdata;
    logic [4:0]  ewreg;
  } vec_t;

  typedef struct {
    logic [31:0] res, wdata;
    logic [4:0]  wreg;
    logic [3:0]  ctl;
  } exp_t;

  vec_t vecs[14];
  exp_t sb[$];
  int unsigned n_applied = 0;
  int unsigned n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    ALUOp = t.op; rs_in = t.rs; rt_in = t.rt; rd_in = t.rd;
    ReadData1_in = t.d1; ReadData2_in = t.d2; SignExtend_in = t.imm;
    {RegWrite, MemtoReg, MemWrite, MemRead, ALUSrc, RegDst} = t.ctl;
    WB_RegWrite = t.wbwe; WB_WriteReg = t.wbreg; WB_Data = t.wbdata;
  endtask

  task automatic sb_check(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      chk({name, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({name, "_res"},   ALUResult_out, e.res);
      chk({name, "_wdata"}, WriteData_out, e.wdata);
      chk({name, "_wreg"},  32'(WriteReg_out), 32'(e.wreg));
      chk({name, "_ctl"},   32'({RegWriteOut, MemtoRegOut, MemWriteOut, MemReadOut}), 32'(e.ctl));
    end
  endtask

  // Called #1 after an edge: single-cycle op must not stall and must land at the next edge.
  task automatic apply_vec(input vec_t t, input string name);
    drive(t);
    #1;
    chk({name, "_stall"}, 32'(stall_o), 32'd0);
    sb.push_back('{res: t.eres, wdata: t.ewdata, wreg: t.ewreg, ctl: t.ctl[5:2]});
    @(posedge clk); #1;
    sb_check(name);
  endtask

  function automatic vec_t mul_vec(input logic [31:0] a, input logic [31:0] b, input logic [31:0] p);
    return '{ALU_MUL, 5'd1, 5'd2, 5'd3, a, b, 32'd0, 6'b100001, 1'b0, 5'd0, 32'd0, p, b, 5'd3};
  endfunction

  task automatic run_mul(input vec_t t, input string name);
    int unsigned cyc;
    drive(t);
    sb.push_back('{res: t.eres, wdata: t.ewdata, wreg: t.ewreg, ctl: t.ctl[5:2]});
    #1;
    cyc = 0;
    while (stall_o && cyc < 40) begin
      cyc++;
      @(posedge clk); #1;
      chk({name, "_bubble"}, 32'({RegWriteOut, MemtoRegOut, MemWriteOut, MemReadOut}), 32'd0);
    end
    chk({name, "_stall_cycles"}, 32'(cyc), 32'd33);
    @(posedge clk); #1;
    sb_check(name);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t t;
    vecs[0]  = '{ALU_ADD, 5'd1,  5'd2,  5'd3,  32'd5, 32'd7, 32'd0, 6'b100001, 1'b0, 5'd0, 32'd0, 32'd12, 32'd7, 5'd3};
    vecs[1]  = '{ALU_ADD, 5'd4,  5'd5,  5'd6,  32'd60, 32'd40, 32'd0, 6'b100001, 1'b0, 5'd0, 32'd0, 32'd100, 32'd40, 5'd6};
    vecs[2]  = '{ALU_SUB, 5'd6,  5'd7,  5'd0,  32'd1, 32'd9, 32'd1, 6'b100011, 1'b1, 5'd6, 32'd200, 32'd99, 32'd9, 5'd0};
    vecs[3]  = '{ALU_SUB, 5'd0,  5'd7,  5'd11, 32'd50, 32'd9, 32'd1, 6'b100011, 1'b1, 5'd0, 32'd200, 32'd49, 32'd9, 5'd11};
    vecs[4]  = '{ALU_ADD, 5'd9,  5'd10, 5'd12, 32'd1, 32'd2, 32'd0, 6'b001001, 1'b1, 5'd10, 32'd200, 32'd201, 32'd200, 5'd12};
    vecs[5]  = '{ALU_ADD, 5'd12, 5'd0,  5'd13, 32'd3, 32'd4, 32'd0, 6'b100001, 1'b0, 5'd0, 32'd0, 32'd7, 32'd4, 5'd13};
    vecs[6]  = '{ALU_SLT, 5'd16, 5'd14, 5'd15, 32'hFFFF_FFFD, 32'd2, 32'd0, 6'b010100, 1'b0, 5'd0, 32'd0, 32'd1, 32'd2, 5'd14};
    vecs[7]  = '{ALU_SLT, 5'd16, 5'd14, 5'd17, 32'd2, 32'hFFFF_FFFD, 32'd0, 6'b100001, 1'b0, 5'd0, 32'd0, 32'd0, 32'hFFFF_FFFD, 5'd17};
    vecs[8]  = '{ALU_ADD, 5'd18, 5'd19, 5'd20, 32'hFFFF_FFFF, 32'd1, 32'd0, 6'b100001, 1'b0, 5'd0, 32'd0, 32'd0, 32'd1, 5'd20};
    vecs[9]  = '{ALU_AND, 5'd21, 5'd22, 5'd23, 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 6'b100001, 1'b0, 5'd0, 32'd0, 32'h0000_F000, 32'h0000_FF00, 5'd23};
    vecs[10] = '{ALU_OR,  5'd21, 5'd22, 5'd23, 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 6'b100001, 1'b0, 5'd0, 32'd0, 32'h0000_FFF0, 32'h0000_FF00, 5'd23};
    vecs[11] = '{ALU_NOR, 5'd21, 5'd22, 5'd23, 32'd0, 32'd0, 32'd0, 6'b100001, 1'b0, 5'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 5'd23};
    vecs[12] = '{ALU_SLL, 5'd21, 5'd22, 5'd23, 32'd0, 32'd3, 32'h0000_0100, 6'b100001, 1'b0, 5'd0, 32'd0, 32'd48, 32'd3, 5'd23};
    vecs[13] = '{4'b0101, 5'd21, 5'd22, 5'd23, 32'd5, 32'd6, 32'd0, 6'b101001, 1'b0, 5'd0, 32'd0, 32'd0, 32'd6, 5'd23};

    // Reset state
    rst_n = 1'b0; flush_i = 1'b0;
    drive('{ALU_ADD, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 6'd0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd0});
    repeat (2) @(posedge clk);
    #1;
    sb.push_back('{res: 32'd0, wdata: 32'd0, wreg: 5'd0, ctl: 4'd0});
    sb_check("reset");
    chk("reset_stall", 32'(stall_o), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

    // Multiply, then a back-to-back multiply that must truncate to the low word
    run_mul(mul_vec(32'd7, 32'd6, 32'd42), "mul7x6");
    run_mul(mul_vec(32'h0001_0001, 32'h0001_0001, 32'h0002_0001), "mul_trunc");

    // Flush during BUSY cycle 10
    drive(mul_vec(32'd5, 32'd9, 32'd45));
    repeat (10) @(posedge clk);
    #1;
    flush_i = 1'b1;
    #1;
    chk("flush_stall_drop", 32'(stall_o), 32'd0);
    @(posedge clk); #1;
    chk("flush_bubble_ctl", 32'({RegWriteOut, MemtoRegOut, MemWriteOut, MemReadOut}), 32'd0);
    chk("flush_data_hold", ALUResult_out, 32'h0002_0001);
    flush_i = 1'b0;
    apply_vec(vecs[0], "after_flush");

    // Reset in the middle of a multiply
    drive(mul_vec(32'd7, 32'd6, 32'd42));
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    sb.push_back('{res: 32'd0, wdata: 32'd0, wreg: 5'd0, ctl: 4'd0});
    sb_check("mid_reset");
    chk("mid_reset_stall", 32'(stall_o), 32'd0);
    rst_n = 1'b1;
    t = vecs[0];
    t.rd = 5'd9; t.ewreg = 5'd9;
    apply_vec(t, "after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_err);
    $finish;
  end

endmodule
